nn_output_sequencer: RTL and testbench

- Drains one layer's activation outputs into the next stage after the activation modules settle.
- Steps the 16:1 output mux select from neuron 0 to neuron num_neurons-1.
- Writes each selected byte to the input FIFO for intermediate layers, or to data memory for the last layer.
- Sits between the activation stage, the 16:1 output mux, the input FIFO and the memory write port. Signals layer completion to the top-level NN controller.

---
 rtl/nn_output_sequencer.sv | 151 +++++++++++++++
 tb/tb_nn_output_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_output_sequencer.sv
// -----------------------------------------------------------------------------
// nn_output_sequencer
//
// Drains one layer's activation outputs into the next stage once the
// activation modules have settled. The 16:1 output mux select is stepped from
// neuron 0 to neuron num_neurons-1. Each selected byte is written to the input
// FIFO for an intermediate layer, or to data memory for the last layer. The
// top-level NN controller gets a one-cycle done pulse when the layer is drained.
//
// Ports:
//   clk           in   system clock
//   reset         in   synchronous, active-high reset
//   start         in   one-cycle pulse: activation outputs valid, begin drain
//   num_neurons   in   active neurons this layer (clamped to N_MAX), latched on start
//   last_layer    in   1 = write to memory, 0 = write to input FIFO, latched on start
//   mem_base      in   memory base address for last-layer results, latched on start
//   sel           out  output-mux select (current neuron index)
//   mux_y         in   output-mux data, combinational from sel
//   fifo_full     in   input FIFO full (stalls an intermediate-layer drain)
//   fifo_wr_en    out  input FIFO write strobe
//   fifo_wr_data  out  input FIFO write data
//   mem_we        out  memory write enable
//   mem_addr      out  memory write address (base + index, wraps modulo 256)
//   mem_wdata     out  memory write data
//   busy          out  drain in progress
//   done          out  one-cycle pulse: layer drain complete
// -----------------------------------------------------------------------------
module nn_output_sequencer #(
    parameter int N_MAX  = 16,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [4:0]        num_neurons,
    input  logic              last_layer,
    input  logic [7:0]        mem_base,
    output logic [3:0]        sel,
    input  logic [DATA_W-1:0] mux_y,
    input  logic              fifo_full,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_wr_data,
    output logic              mem_we,
    output logic [7:0]        mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // A layer can never drive more neurons than the mux has inputs.
    function automatic logic [4:0] clamp_count(input logic [4:0] n);
        if (n > 5'(N_MAX)) begin
            return 5'(N_MAX);
        end
        return n;
    endfunction

    state_t     state_q, state_d;
    logic [4:0] idx_q,   idx_d;
    logic [4:0] cnt_q,   cnt_d;
    logic       last_q,  last_d;
    logic [7:0] base_q,  base_d;

    logic in_write;
    logic write_fire;
    logic last_write;

    assign in_write = (state_q == ST_WRITE);

    // Memory never stalls; the FIFO path stalls while the FIFO is full.
    assign write_fire = in_write && (last_q || !fifo_full);
    assign last_write = (idx_q == (cnt_q - 5'd1));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        base_d  = base_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (num_neurons == 5'd0) begin
                        // Empty layer: report completion without any write.
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WRITE;
                        cnt_d   = clamp_count(num_neurons);
                        last_d  = last_layer;
                        base_d  = mem_base;
                        idx_d   = 5'd0;
                    end
                end
            end

            ST_WRITE: begin
                if (write_fire) begin
                    if (last_write) begin
                        state_d = ST_DONE;
                        idx_d   = 5'd0;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= 5'd0;
            cnt_q   <= 5'd0;
            last_q  <= 1'b0;
            base_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            base_q  <= base_d;
        end
    end

    // Strobes decode the registered state directly so the FIFO sees a write
    // on the same edge its full flag was evaluated against.
    assign sel          = idx_q[3:0];
    assign fifo_wr_en   = in_write && !last_q && !fifo_full;
    assign mem_we       = in_write && last_q;
    assign mem_addr     = base_q + {3'b000, idx_q};
    assign fifo_wr_data = mux_y;
    assign mem_wdata    = mux_y;
    assign busy         = in_write;
    assign done         = (state_q == ST_DONE);

endmodule

// File: tb/tb_nn_output_sequencer.sv
module tb_nn_output_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [4:0] num_neurons;
    logic       last_layer;
    logic [7:0] mem_base;
    logic [3:0] sel;
    logic [7:0] mux_y;
    logic       fifo_full;
    logic       fifo_wr_en;
    logic [7:0] fifo_wr_data;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       busy;
    logic       done;

    always #5 clk = ~clk;

    nn_output_sequencer #(.N_MAX(16), .DATA_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .num_neurons  (num_neurons),
        .last_layer   (last_layer),
        .mem_base     (mem_base),
        .sel          (sel),
        .mux_y        (mux_y),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .busy         (busy),
        .done         (done)
    );

    // Output mux model: the activation values of the current layer.
    logic [7:0] mux_tbl [16];
    assign mux_y = mux_tbl[sel];

    typedef struct {
        int         lc;
        bit         tgt;
        logic [7:0] addr;
        logic [7:0] data;
        logic [3:0] s;
    } wr_t;

    typedef struct {
        int         n;
        bit         last;
        logic [7:0] base;
        int         fk;        // 0 never full, 1 random full, 2 full for cycles 2..4
        int         restart;   // cycle of a spurious start, -1 for none
        bit         rnd_data;
        int         exp_writes;
        int         exp_done;  // -1: only the model's value is used
    } vec_t;

    int  checks   = 0;
    int  failures = 0;
    wr_t obs [$];
    int  lc, done_cnt, done_lc, busy_err, both_err, full_err, hold_err;
    int  exp_done_lc;
    bit  busy_chk_en;
    bit  full_pat [400];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic settle_sample();
        #1;
        if (fifo_wr_en === 1'b1) obs.push_back('{lc, 1'b0, 8'h00, fifo_wr_data, sel});
        if (mem_we === 1'b1)     obs.push_back('{lc, 1'b1, mem_addr, mem_wdata, sel});
        if (fifo_wr_en === 1'b1 && fifo_full === 1'b1) full_err++;
        if (fifo_wr_en === 1'b1 && mem_we === 1'b1) both_err++;
        if (done === 1'b1) begin
            done_cnt++;
            done_lc = lc;
        end
        if (busy_chk_en && busy !== ((lc >= 1 && lc < exp_done_lc) ? 1'b1 : 1'b0)) busy_err++;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        lc++;
    endtask

    task automatic run_layer(input vec_t v, input string tag);
        int k, w, c;
        int exp_wlc [16];
        for (int i = 0; i < 16; i++)
            mux_tbl[i] = v.rnd_data ? 8'($urandom) : 8'(8'h10 + i);
        for (int i = 0; i < 400; i++) begin
            case (v.fk)
                1:       full_pat[i] = ($urandom_range(0, 2) == 0);
                2:       full_pat[i] = (i >= 2 && i <= 4);
                default: full_pat[i] = 1'b0;
            endcase
        end
        // Reference: min(n,16) writes, one per cycle from cycle 1 on, skipping
        // cycles where an intermediate layer sees a full FIFO; done follows.
        k = (v.n > 16) ? 16 : v.n;
        w = 0;
        c = 1;
        while (w < k && c < 390) begin
            if (!v.last && full_pat[c]) begin
                c++;
            end else begin
                exp_wlc[w] = c;
                w++;
                c++;
            end
        end
        exp_done_lc = c;

        obs.delete();
        lc = 0; done_cnt = 0; done_lc = -1;
        busy_err = 0; both_err = 0; full_err = 0; hold_err = 0;
        busy_chk_en = 1'b1;

        start       = 1'b1;
        num_neurons = 5'(v.n);
        last_layer  = v.last;
        mem_base    = v.base;
        fifo_full   = full_pat[0];
        settle_sample();
        adv();
        // Inputs after acceptance are scrambled; they must have no effect.
        num_neurons = 5'($urandom);
        last_layer  = 1'($urandom);
        mem_base    = 8'($urandom);
        while (done_cnt == 0 && lc < 300) begin
            fifo_full = full_pat[lc];
            if (lc == v.restart) begin
                start       = 1'b1;
                num_neurons = 5'd9;
                last_layer  = ~v.last;
                mem_base    = 8'h55;
            end else begin
                start = 1'b0;
            end
            settle_sample();
            if (v.fk == 2 && lc >= 2 && lc <= 4 && sel !== 4'd1) hold_err++;
            adv();
        end
        start     = 1'b0;
        fifo_full = 1'b0;
        busy_chk_en = 1'b0;

        chk({tag, " writes"}, obs.size(), v.exp_writes);
        if (v.exp_done >= 0) chk({tag, " done cycle"}, done_lc, v.exp_done);
        chk({tag, " done cycle vs model"}, done_lc, exp_done_lc);
        chk({tag, " done pulses"}, done_cnt, 1);
        chk({tag, " busy errors"}, busy_err, 0);
        chk({tag, " dual-target writes"}, both_err, 0);
        chk({tag, " writes while full"}, full_err, 0);
        if (v.fk == 2) chk({tag, " sel hold errors"}, hold_err, 0);
        for (int i = 0; i < obs.size() && i < k; i++) begin
            chk($sformatf("%s w%0d target", tag, i), obs[i].tgt, v.last);
            chk($sformatf("%s w%0d data", tag, i), obs[i].data, mux_tbl[i]);
            chk($sformatf("%s w%0d sel", tag, i), obs[i].s, i);
            chk($sformatf("%s w%0d cycle", tag, i), obs[i].lc, exp_wlc[i]);
            if (v.last) chk($sformatf("%s w%0d addr", tag, i), obs[i].addr, 8'(v.base + 8'(i)));
        end
    endtask

    vec_t vecs [8];
    vec_t rv;

    initial begin
        vecs[0] = '{4,  1'b0, 8'h00, 0, -1, 1'b0, 4,  5};   // basic FIFO drain
        vecs[1] = '{3,  1'b0, 8'h00, 2, -1, 1'b0, 3,  7};   // backpressure
        vecs[2] = '{16, 1'b1, 8'hF8, 0, -1, 1'b0, 16, 17};  // memory, address wrap
        vecs[3] = '{0,  1'b0, 8'h00, 0, -1, 1'b0, 0,  1};   // empty layer
        vecs[4] = '{20, 1'b0, 8'h00, 0, -1, 1'b0, 16, 17};  // clamp to 16
        vecs[5] = '{5,  1'b0, 8'h00, 0, 2,  1'b0, 5,  6};   // start during WRITE
        vecs[6] = '{1,  1'b1, 8'hFF, 0, -1, 1'b1, 1,  2};   // single neuron
        vecs[7] = '{17, 1'b1, 8'h10, 1, -1, 1'b1, 16, 17};  // memory ignores fifo_full

        for (int i = 0; i < 16; i++) mux_tbl[i] = 8'(8'h10 + i);
        reset = 1'b1; start = 1'b0; num_neurons = 5'd0; last_layer = 1'b0;
        mem_base = 8'h00; fifo_full = 1'b0;
        busy_chk_en = 1'b0; lc = 0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset sel", sel, 4'd0);
        chk("reset fifo_wr_en", fifo_wr_en, 1'b0);
        chk("reset mem_we", mem_we, 1'b0);
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset mem_addr", mem_addr, 8'h00);
        chk("reset fifo_wr_data", fifo_wr_data, 8'h10);
        chk("reset mem_wdata", mem_wdata, 8'h10);
        reset = 1'b0;
        adv();

        for (int i = 0; i < 8; i++) run_layer(vecs[i], $sformatf("vec%0d", i));

        // Reset on the 3rd write of a 10-neuron drain.
        for (int i = 0; i < 16; i++) mux_tbl[i] = 8'(8'h10 + i);
        obs.delete(); lc = 0; done_cnt = 0; busy_chk_en = 1'b0;
        start = 1'b1; num_neurons = 5'd10; last_layer = 1'b0; fifo_full = 1'b0;
        settle_sample();
        adv();
        start = 1'b0;
        settle_sample();
        adv();
        settle_sample();
        adv();
        reset = 1'b1;
        settle_sample();
        adv();
        reset = 1'b0;
        settle_sample();
        chk("rst fifo_wr_en", fifo_wr_en, 1'b0);
        chk("rst busy", busy, 1'b0);
        chk("rst sel", sel, 4'd0);
        chk("rst done", done, 1'b0);
        adv();
        repeat (3) begin
            settle_sample();
            adv();
        end
        chk("rst writes issued", obs.size(), 3);
        if (obs.size() == 3) chk("rst 3rd write data", obs[2].data, 8'h12);
        chk("rst no done", done_cnt, 0);
        rv = '{10, 1'b0, 8'h00, 0, -1, 1'b0, 10, 11};
        run_layer(rv, "post-reset");

        // Randomized layers against the reference model.
        for (int t = 0; t < 25; t++) begin
            rv.n          = $urandom_range(0, 20);
            rv.last       = 1'($urandom);
            rv.base       = 8'($urandom);
            rv.fk         = 1;
            rv.restart    = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : -1;
            rv.rnd_data   = 1'b1;
            rv.exp_writes = (rv.n > 16) ? 16 : rv.n;
            rv.exp_done   = -1;
            run_layer(rv, $sformatf("rnd%0d", t));
        end

        begin
            int d0, s0;
            d0 = done_cnt;
            s0 = obs.size();
            settle_sample();
            adv();
            chk("idle no extra done", done_cnt, d0);
            chk("idle no extra writes", obs.size(), s0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
